rev_seq_adder: RTL and testbench

REV_SEQ_ADDER -- requirements
Module: rev_seq_adder

---
 rtl/rev_pkg.sv | 17 +
 rtl/rev_fa.sv | 43 ++++
 rtl/rev_seq_adder.sv | 128 ++++++++++++
 tb/tb_rev_seq_adder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rev_pkg.sv
// Shared definitions for the reversible sequential adder.
// Contents:
//   state_t    - control FSM encoding (IDLE, CALC, DONE)
//   MODE_PERES - cell select value for the Peres-based full adder
//   MODE_HNG   - cell select value for the HNG-based full adder
package rev_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_PERES = 1'b0;
  localparam logic MODE_HNG   = 1'b1;

endpackage

// File: rtl/rev_fa.sv
// Single-bit full adder built from reversible gates.
// Ports:
//   a, b  - addend bits
//   cin   - carry in
//   mode  - MODE_PERES: two cascaded Peres gates, MODE_HNG: one HNG gate
//   sum   - sum bit
//   cout  - carry out
// Garbage outputs of the gates (pass-through lines) are not materialised.
module rev_fa
  import rev_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic mode,
  output logic sum,
  output logic cout
);

  // Peres gate: P = A, Q = A ^ B, R = (A & B) ^ C.
  // First gate (a, b, 0): Q = a^b, R = a&b.
  // Second gate (a^b, cin, a&b): Q = sum, R = carry.
  logic peres1_q;
  logic peres1_r;
  logic peres2_q;
  logic peres2_r;

  // HNG gate: P = A, Q = B, R = A^B^C, S = ((A^B)&C) ^ (A&B) ^ D with D = 0.
  logic hng_r;
  logic hng_s;

  assign peres1_q = a ^ b;
  assign peres1_r = (a & b) ^ 1'b0;
  assign peres2_q = peres1_q ^ cin;
  assign peres2_r = (peres1_q & cin) ^ peres1_r;

  assign hng_r = a ^ b ^ cin;
  assign hng_s = ((a ^ b) & cin) ^ (a & b) ^ 1'b0;

  assign sum  = (mode == MODE_HNG) ? hng_r : peres2_q;
  assign cout = (mode == MODE_HNG) ? hng_s : peres2_r;

endmodule

// File: rtl/rev_seq_adder.sv
// Multi-cycle adder that processes CHUNK bits per cycle through a ripple
// chain of reversible full-adder cells.
// Ports:
//   clk, rst           - clock (rising edge), asynchronous active-high reset
//   in_valid, in_ready - operand handshake (accepted only in IDLE)
//   a, b, cin, mode    - operands, carry-in, cell select (captured on accept)
//   out_valid, out_ready - result handshake (result held in DONE)
//   sum, cout, ovf     - registered result, carry out, signed overflow
module rev_seq_adder
  import rev_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NB = WIDTH / CHUNK;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("rev_seq_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t           state;
  state_t           state_nxt;
  logic [BW-1:0]    beat;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             mode_q;
  logic             accept;
  logic             last;
  int               lo;
  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK-1:0] s_slice;
  logic [CHUNK:0]   c;

  assign accept  = (state == ST_IDLE) && in_valid;
  assign last    = (beat == LAST_BEAT);
  assign lo      = int'(beat) * CHUNK;
  assign a_slice = a_q[lo +: CHUNK];
  assign b_slice = b_q[lo +: CHUNK];

  // Ripple chain for the current beat; the registered carry seeds it.
  assign c[0] = carry_q;
  for (genvar i = 0; i < CHUNK; i++) begin : g_chain
    rev_fa u_fa (
      .a    (a_slice[i]),
      .b    (b_slice[i]),
      .cin  (c[i]),
      .mode (mode_q),
      .sum  (s_slice[i]),
      .cout (c[i+1])
    );
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_CALC;
      end
      ST_CALC: begin
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      beat    <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        beat    <= '0;
        carry_q <= cin;
      end else if (state == ST_CALC) begin
        sum[lo +: CHUNK] <= s_slice;
        carry_q          <= c[CHUNK];
        if (!last) begin
          beat <= beat + 1'b1;
        end else begin
          // Final beat: c[CHUNK-1] is the carry into the MSB.
          cout <= c[CHUNK];
          ovf  <= c[CHUNK] ^ c[CHUNK-1];
        end
      end
    end
  end

  // Operand capture; data path registers carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= a;
      b_q    <= b;
      mode_q <= mode;
    end
  end

endmodule

// File: tb/tb_rev_seq_adder.sv
module tb_rev_seq_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit small_done [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} packed as bits [w+1], [w], [w-1:0].
  function automatic logic [63:0] model(input int w, input longint unsigned av,
                                        input longint unsigned bv, input bit cv);
    longint unsigned tot, half, full;
    longint sa, sb, ss;
    logic [63:0] r;
    full = 64'd1 << w;
    half = 64'd1 << (w - 1);
    tot  = av + bv + longint'(cv);
    sa   = (av >= half) ? longint'(av) - longint'(full) : longint'(av);
    sb   = (bv >= half) ? longint'(bv) - longint'(full) : longint'(bv);
    ss   = sa + sb + longint'(cv);
    r    = tot;
    r[w+1] = (ss >= longint'(half)) || (ss < -longint'(half));
    return r;
  endfunction

  // ---------------- 16-bit, CHUNK=4 instance ----------------
  logic        rst16, iv16, ir16, cin16, mode16, ov16, or16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;
  logic [63:0] q16[$];

  rev_seq_adder #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk       (clk),
    .rst       (rst16),
    .in_valid  (iv16),
    .in_ready  (ir16),
    .a         (a16),
    .b         (b16),
    .cin       (cin16),
    .mode      (mode16),
    .out_valid (ov16),
    .out_ready (or16),
    .sum       (sum16),
    .cout      (cout16),
    .ovf       (ovf16)
  );

  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst16 && ov16 && or16) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u16 unexpected result: actual sum %0h, no operation outstanding", sum16);
      end else begin
        e = q16.pop_front();
        chk("u16 sum", 64'(sum16), 64'(e[15:0]));
        chk("u16 cout", 64'(cout16), 64'(e[16]));
        chk("u16 ovf", 64'(ovf16), 64'(e[17]));
      end
    end
  end

  task automatic issue16(input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic mv, input int hold);
    int t, lat;
    logic [15:0] s0;
    logic c0, o0;
    t = 0;
    while (!ir16 && t < 50) begin @(posedge clk); #1; t++; end
    chk("u16 in_ready before accept", 64'(ir16), 64'd1);
    a16 = av; b16 = bv; cin16 = cv; mode16 = mv; iv16 = 1'b1; or16 = 1'b0;
    q16.push_back(model(16, av, bv, cv));
    @(posedge clk); #1;
    // Disturb the inputs while the operation is in flight.
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    mode16 = 1'($urandom); iv16 = 1'($urandom);
    lat = 0;
    while (!ov16 && lat < 20) begin
      chk("u16 in_ready busy", 64'(ir16), 64'd0);
      @(posedge clk); #1;
      lat++;
      iv16 = 1'($urandom);
    end
    chk("u16 latency", 64'(lat), 64'd4);
    s0 = sum16; c0 = cout16; o0 = ovf16;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      iv16 = 1'($urandom);
      chk("u16 hold sum", 64'(sum16), 64'(s0));
      chk("u16 hold cout", 64'(cout16), 64'(c0));
      chk("u16 hold ovf", 64'(ovf16), 64'(o0));
      chk("u16 hold out_valid", 64'(ov16), 64'd1);
      chk("u16 hold in_ready", 64'(ir16), 64'd0);
    end
    or16 = 1'b1;
    @(posedge clk); #1;
    chk("u16 in_ready after handshake", 64'(ir16), 64'd1);
    chk("u16 out_valid after handshake", 64'(ov16), 64'd0);
    iv16 = 1'b0;
  endtask

  initial begin
    int t;
    rst16 = 1'b1; iv16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; mode16 = 1'b0; or16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("u16 reset in_ready", 64'(ir16), 64'd1);
    chk("u16 reset out_valid", 64'(ov16), 64'd0);
    chk("u16 reset sum", 64'(sum16), 64'd0);
    chk("u16 reset cout", 64'(cout16), 64'd0);
    chk("u16 reset ovf", 64'(ovf16), 64'd0);
    @(negedge clk) rst16 = 1'b0;

    issue16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    issue16(16'h7FFF, 16'h0001, 1'b0, 1'b1, 0);
    issue16(16'h1234, 16'h4321, 1'b1, 1'b1, 0);
    issue16(16'h8000, 16'h8000, 1'b1, 1'b0, 5);

    // Asynchronous reset while beat 2 is being computed.
    a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; mode16 = 1'b0; iv16 = 1'b1; or16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst16 = 1'b1;
    #1;
    chk("u16 mid-calc reset out_valid", 64'(ov16), 64'd0);
    chk("u16 mid-calc reset sum", 64'(sum16), 64'd0);
    chk("u16 mid-calc reset in_ready", 64'(ir16), 64'd1);
    chk("u16 mid-calc reset cout", 64'(cout16), 64'd0);
    chk("u16 mid-calc reset ovf", 64'(ovf16), 64'd0);
    @(negedge clk) rst16 = 1'b0;
    issue16(16'd3, 16'd4, 1'b0, 1'b0, 0);

    for (int n = 0; n < 150; n++)
      issue16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));

    chk("u16 scoreboard drained", 64'(q16.size()), 64'd0);
    t = 0;
    while (!(small_done[0] && small_done[1]) && t < 40000) begin @(posedge clk); t++; end
    chk("w4 benches completed", {62'd0, small_done[1], small_done[0]}, 64'd3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- 4-bit instances: CHUNK=1 and CHUNK=4 ----------------
  for (genvar g = 0; g < 2; g++) begin : g_small
    localparam int CH = (g == 0) ? 1 : 4;
    localparam int NB = 4 / CH;

    logic       rst, iv, ir, cin, mode, ov, ordy, cout, ovf;
    logic [3:0] a, b, sum;
    logic [63:0] q[$];

    rev_seq_adder #(.WIDTH(4), .CHUNK(CH)) u (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .mode      (mode),
      .out_valid (ov),
      .out_ready (ordy),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
    );

    always @(negedge clk) begin
      logic [63:0] e;
      if (!rst && ov && ordy) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL w4c%0d unexpected result: actual sum %0h, no operation outstanding", CH, sum);
        end else begin
          e = q.pop_front();
          chk($sformatf("w4c%0d sum", CH), 64'(sum), 64'(e[3:0]));
          chk($sformatf("w4c%0d cout", CH), 64'(cout), 64'(e[4]));
          chk($sformatf("w4c%0d ovf", CH), 64'(ovf), 64'(e[5]));
        end
      end
    end

    initial begin
      int t, lat;
      rst = 1'b1; iv = 1'b0; a = '0; b = '0; cin = 1'b0; mode = 1'b0; ordy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("w4c%0d reset in_ready", CH), 64'(ir), 64'd1);
      chk($sformatf("w4c%0d reset out_valid", CH), 64'(ov), 64'd0);
      @(negedge clk) rst = 1'b0;
      for (int m = 0; m < 2; m++) begin
        for (int v = 0; v < 512; v++) begin
          t = 0;
          while (!ir && t < 50) begin @(posedge clk); #1; t++; end
          chk($sformatf("w4c%0d in_ready before accept", CH), 64'(ir), 64'd1);
          a = 4'(v); b = 4'(v >> 4); cin = 1'(v >> 8); mode = 1'(m); iv = 1'b1;
          q.push_back(model(4, a, b, cin));
          @(posedge clk); #1;
          a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom);
          mode = 1'($urandom); iv = 1'($urandom);
          lat = 0;
          while (!ov && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            iv = 1'($urandom);
          end
          chk($sformatf("w4c%0d latency", CH), 64'(lat), 64'(NB));
          @(posedge clk); #1;
          chk($sformatf("w4c%0d in_ready after handshake", CH), 64'(ir), 64'd1);
          iv = 1'b0;
        end
      end
      chk($sformatf("w4c%0d scoreboard drained", CH), 64'(q.size()), 64'd0);
      small_done[g] = 1'b1;
    end
  end

endmodule
